// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: one full-subtractor cell per clock, LSB first,
// with start/busy/done handshake and unsigned-borrow / signed-overflow flags.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, diff_nxt;
  logic [CW-1:0]    cnt;
  logic             br, br_nxt, ai, bi, di, last;

  // Single full-subtractor cell fed from the LSB of each operand shift register.
  always_comb begin
    ai       = sa[0];
    bi       = sb[0];
    di       = ai ^ bi ^ br;
    br_nxt   = (~ai & bi) | (~(ai ^ bi) & br);
    last     = (cnt == CW'(WIDTH - 1));
    diff_nxt = diff >> 1;
    diff_nxt[WIDTH-1] = di;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      diff       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            cnt <= '0;
            br  <= 1'b0;
          end
        end
        RUN: begin
          sa   <= sa >> 1;
          sb   <= sb >> 1;
          diff <= diff_nxt;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          // On the MSB the cell inputs are a/b sign bits and di is the result sign.
          if (last) begin
            borrow_out <= br_nxt;
            overflow   <= (ai != bi) & (di != ai);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: WIDTH=8 instance plus a WIDTH=1
// instance exercising the half-subtractor truth table.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, bo8, ov8;
  logic [7:0] diff8;
  logic       busy1, done1, bo1, ov1;
  logic [0:0] diff1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8), .overflow(ov8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1), .overflow(ov1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one WIDTH=8 operation; optionally re-pulse start with other operands
  // inj_at RUN edges in (0 = never). Checks latency, busy and results.
  task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input logic eo, input int inj_at);
    int n = 0;
    int busy_bad = 0;
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = ~av; b8 = av ^ 8'h5A;
    while (!done8 && n < 20) begin
      if (!busy8) busy_bad++;
      if (inj_at != 0 && n == inj_at) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start8 = 1'b0;
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_busy_run"}, busy_bad, 0);
    chk({tag, "_busy_done"}, busy8, 1'b0);
    chk({tag, "_diff"}, diff8, ed);
    chk({tag, "_borrow"}, bo8, eb);
    chk({tag, "_ovf"}, ov8, eo);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done8, 1'b0);
  endtask

  task automatic run1(input string tag, input logic av, input logic bv,
                      input logic ed, input logic eb);
    int n = 0;
    @(negedge clk);
    a1 = av; b1 = bv; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; a1 = ~av; b1 = ~bv;
    while (!done1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_diff"}, diff1, ed);
    chk({tag, "_borrow"}, bo1, eb);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int seen;
    #12;
    chk("rst_busy", busy8, 1'b0);
    chk("rst_done", done8, 1'b0);
    chk("rst_diff", diff8, 8'h00);
    chk("rst_borrow", bo8, 1'b0);
    chk("rst_ovf", ov8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run8("t1", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    run8("t2", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    run8("t3a", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run8("t3b", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    run8("t4", 8'hA5, 8'h3C, 8'h69, 1'b0, 1'b1, 3);
    #1;
    chk("t4_no_restart", busy8, 1'b0);
    run8("t2b", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);

    // T5: abort in the middle of RUN, outputs nonzero beforehand
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("t5_busy_before", busy8, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy8, 1'b0);
    chk("t5_done", done8, 1'b0);
    chk("t5_diff", diff8, 8'h00);
    chk("t5_borrow", bo8, 1'b0);
    chk("t5_ovf", ov8, 1'b0);
    seen = 0;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
      n++;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    chk("t5_no_done", seen, 0);
    run8("t5_fresh", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 0);

    // T6: WIDTH=1 half-subtractor table
    run1("t6_00", 1'b0, 1'b0, 1'b0, 1'b0);
    run1("t6_10", 1'b1, 1'b0, 1'b1, 1'b0);
    run1("t6_11", 1'b1, 1'b1, 1'b0, 1'b0);
    run1("t6_01", 1'b0, 1'b1, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
